bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_if.sv | 29 ++
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_bin2bcd_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Purpose  : Start/done handshake and data bundle for the sequential
//            binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble binary-to-BCD converter, one shift per
//            clock, with overflow flag when DIGITS is too small.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  wire              clk,
    input  wire              rst,
    bin2bcd_seq_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ACC_W = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sh;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ov;
    logic             r_busy;
    logic             r_done;
    logic [ACC_W-1:0] r_bcd;
    logic             r_ovf;

    logic [ACC_W-1:0] w_adj;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ov_next;

    // Digit-local add-3 correction; no carries cross digit boundaries.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                          : r_acc[4*i +: 4];
    end

    assign w_acc_next = {w_adj[ACC_W-2:0], r_sh[WIDTH-1]};
    assign w_ov_next  = r_ov | w_adj[ACC_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ov    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sh    <= bus.bin;
                        r_acc   <= '0;
                        r_ov    <= 1'b0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_sh  <= r_sh << 1;
                    r_ov  <= w_ov_next;
                    r_cnt <= r_cnt - 1'b1;
                    // Publish only the final shift so bcd never shows partial digits.
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd   <= w_acc_next;
                        r_ovf   <= w_ov_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Self-checking bench for bin2bcd_seq over four parameter sets,
//            compared against an arithmetic decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5))  if0 ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(4))  if1 ();
    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3))  if2 ();
    bin2bcd_seq_if #(.WIDTH(32), .DIGITS(10)) if3 ();

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5))  u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(4))  u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3))  u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    int          n_vec = 0;
    int          n_err = 0;
    int          sel   = 0;
    logic        busy_m;
    logic        done_m;
    logic        ovf_m;
    logic [63:0] bcd_m;

    always_comb begin
        busy_m = 1'b0;
        done_m = 1'b0;
        ovf_m  = 1'b0;
        bcd_m  = '0;
        case (sel)
            0: begin busy_m = if0.busy; done_m = if0.done; ovf_m = if0.ovf; bcd_m = 64'(if0.bcd); end
            1: begin busy_m = if1.busy; done_m = if1.done; ovf_m = if1.ovf; bcd_m = 64'(if1.bcd); end
            2: begin busy_m = if2.busy; done_m = if2.done; ovf_m = if2.ovf; bcd_m = 64'(if2.bcd); end
            default: begin busy_m = if3.busy; done_m = if3.done; ovf_m = if3.ovf; bcd_m = 64'(if3.bcd); end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d): got %0h expected %0h", tag, sel, got, exp);
        end
    endtask

    function automatic int width_of(input int s);
        case (s)
            0, 1:    return 16;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int digits_of(input int s);
        case (s)
            0:       return 5;
            1:       return 4;
            2:       return 3;
            default: return 10;
        endcase
    endfunction

    // Decimal reference: value mod 10^d written out as packed BCD digits.
    function automatic logic [63:0] ref_bcd(input logic [63:0] v, input int d);
        logic [63:0] r = '0;
        logic [63:0] x = v;
        for (int i = 0; i < d; i++) begin
            r = r | ((x % 64'd10) << (4 * i));
            x = x / 64'd10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [63:0] v, input int d);
        logic [63:0] p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return (v >= p);
    endfunction

    task automatic set_start(input int s, input logic st);
        case (s)
            0:       if0.start = st;
            1:       if1.start = st;
            2:       if2.start = st;
            default: if3.start = st;
        endcase
    endtask

    task automatic set_bin(input int s, input logic [63:0] v);
        case (s)
            0:       if0.bin = v[15:0];
            1:       if1.bin = v[15:0];
            2:       if2.bin = v[7:0];
            default: if3.bin = v[31:0];
        endcase
    endtask

    // One framed conversion; optionally disturbs bin/start mid-shift.
    task automatic convert(input int s, input logic [63:0] v, input bit disturb);
        int          w    = width_of(s);
        int          d    = digits_of(s);
        int          n    = 0;
        int          nb   = 0;
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] vm   = v & mask;
        sel = s;
        @(negedge clk);
        set_bin(s, vm);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        if (busy_m) nb++;
        while (!done_m && n < w + 4) begin
            @(negedge clk);
            n++;
            if (disturb && n == w / 2) begin
                set_bin(s, 64'h5555);
                set_start(s, 1'b1);
            end else begin
                set_start(s, 1'b0);
            end
            if (busy_m) nb++;
        end
        check("latency", 64'(n), 64'(w));
        check("busy_cycles", 64'(nb), 64'(w));
        check("bcd", bcd_m, ref_bcd(vm, d));
        check("ovf", 64'(ovf_m), 64'(ref_ovf(vm, d)));
        @(negedge clk);
        check("done_pulse_width", 64'(done_m), 64'd0);
        check("idle_after_done", 64'(busy_m), 64'd0);
    endtask

    initial begin
        int last;
        int n;
        bit seen_done;

        if0.start = 1'b0; if0.bin = '0;
        if1.start = 1'b0; if1.bin = '0;
        if2.start = 1'b0; if2.bin = '0;
        if3.start = 1'b0; if3.bin = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        sel = 0;
        check("rst_busy", 64'(busy_m), 64'd0);
        check("rst_done", 64'(done_m), 64'd0);
        check("rst_bcd",  bcd_m,       64'd0);
        check("rst_ovf",  64'(ovf_m),  64'd0);
        rst = 1'b0;

        // Directed corner cases
        convert(0, 64'hFFFF, 1'b0);
        check("bcd_65535", bcd_m, 64'h65535);
        convert(0, 64'd0, 1'b0);
        convert(0, 64'd1234, 1'b1);
        check("bcd_1234_held", bcd_m, 64'h01234);
        convert(1, 64'd9999, 1'b0);
        convert(1, 64'd10000, 1'b0);
        check("ovf_10000", 64'(ovf_m), 64'd1);
        convert(1, 64'd65535, 1'b0);
        check("bcd_5535", bcd_m, 64'h5535);
        convert(3, 64'hFFFF_FFFF, 1'b0);
        check("bcd_4294967295", bcd_m, 64'h42_9496_7295);

        // Async reset between edges mid-conversion
        sel = 0;
        @(negedge clk);
        set_bin(0, 64'd4321);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy_m), 64'd0);
        check("async_rst_done", 64'(done_m), 64'd0);
        check("async_rst_bcd",  bcd_m,       64'd0);
        check("async_rst_ovf",  64'(ovf_m),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_m || busy_m) seen_done = 1'b1;
        end
        check("no_done_after_abort", 64'(seen_done), 64'd0);
        convert(0, 64'd1234, 1'b0);

        // Randomised conversions on every parameter set
        for (int i = 0; i < 12; i++) begin
            convert(0, 64'($urandom), 1'b0);
            convert(1, 64'($urandom), 1'b0);
            convert(2, 64'($urandom_range(0, 255)), 1'b0);
            convert(3, 64'($urandom), 1'b0);
        end

        // Exhaustive 8-bit sweep with start held high: back-to-back throughput
        sel = 2;
        last = 0;
        @(negedge clk);
        set_bin(2, 64'd0);
        set_start(2, 1'b1);
        for (int v = 0; v < 256; v++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done_m && n < 20);
            check("sweep_done", 64'(done_m), 64'd1);
            check("sweep_bcd", bcd_m, ref_bcd(64'(v), 3));
            check("sweep_ovf", 64'(ovf_m), 64'd0);
            if (v > 0) check("sweep_period", 64'(cyc - last), 64'd9);
            last = cyc;
            set_bin(2, 64'(v + 1));
            if (v == 255) set_start(2, 1'b0);
        end
        repeat (12) @(negedge clk);
        check("sweep_stops", 64'(busy_m), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
